// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK frame receive controller.
package fsk_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HUNT = 3'd1,
    SYNC = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4,
    CRC  = 3'd5
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hD391;
  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam logic [7:0]  CRC8_INIT     = 8'h00;

endpackage

// File: rtl/fsk_crc8.sv
// Bit-serial CRC-8, MSB first. The crc output updates one cycle after a bit_en strobe.
// It has no backpressure; clr takes priority over bit_en.
module fsk_crc8
  import fsk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic       fb;

  assign fb  = crc_q[7] ^ bit_in;
  assign crc = crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      crc_q <= CRC8_INIT;
    else if (clr)    crc_q <= CRC8_INIT;
    else if (bit_en) crc_q <= {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

endmodule

// File: rtl/fsk_frame_ctrl.sv
// FSK frame receiver: preamble hunt, sync search, length, payload. Bytes and status pulses appear one cycle after the completing bit strobe.
// A byte that completes while the previous one is still unaccepted aborts the frame. Defining FSK_FRAME_CRC_EN adds a trailing CRC-8 byte check.
module fsk_frame_ctrl
  import fsk_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter logic [7:0]  PREAMBLE_MIN = 8'd8,
  parameter logic [7:0]  SYNC_SEARCH  = 8'd32,
  parameter logic [7:0]  MAX_LEN      = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  state_t      state_q, state_d;
  logic [7:0]  alt_q, alt_d, cnt_q, cnt_d, len_q, len_d, byte_q, byte_d;
  logic [14:0] sh_q, sh_d;
  logic [15:0] sh_nx;
  logic        prev_q, prev_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic        start_q, start_d, ok_q, ok_d, err_q, err_d;

  assign sh_nx = {sh_q, bit_in};

`ifdef FSK_FRAME_CRC_EN
  logic [7:0] crc_val;
  logic       crc_clr, crc_en;

  // The CRC covers the length byte and payload; it is cleared while searching for sync.
  assign crc_clr = !enable || (state_q == SYNC);
  assign crc_en  = enable && bit_valid && ((state_q == LEN) || (state_q == DATA));

  fsk_crc8 u_crc8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .bit_en (crc_en),
    .bit_in (bit_in),
    .crc    (crc_val)
  );
`endif

  always_comb begin
    state_d     = state_q;
    alt_d       = alt_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    len_d       = len_q;
    byte_d      = byte_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_last_d  = out_last_q & ~(out_valid_q & out_ready);
    start_d     = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      alt_d   = '0;
      prev_d  = 1'b0;
      cnt_d   = '0;
      sh_d    = '0;
      len_d   = '0;
      byte_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: if (bit_valid) begin
          prev_d = bit_in;
          // alt_q == 0 means no previous bit has been seen since entering HUNT
          if ((alt_q != 8'd0) && (bit_in != prev_q))
            alt_d = (alt_q == 8'hFF) ? alt_q : alt_q + 8'd1;
          else
            alt_d = 8'd1;
          if (alt_d >= PREAMBLE_MIN) begin
            state_d = SYNC;
            alt_d   = '0;
            prev_d  = 1'b0;
          end
        end
        SYNC: if (bit_valid) begin
          sh_d  = sh_nx[14:0];
          cnt_d = cnt_q + 8'd1;
          if (sh_nx == SYNC_WORD) begin
            state_d = LEN;
            start_d = 1'b1;
            sh_d    = '0;
            cnt_d   = '0;
          end else if (cnt_d >= SYNC_SEARCH) begin
            state_d = HUNT;
            sh_d    = '0;
            cnt_d   = '0;
          end
        end
        LEN: if (bit_valid) begin
          sh_d  = sh_nx[14:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            sh_d  = '0;
            cnt_d = '0;
            if ((sh_nx[7:0] == 8'd0) || (sh_nx[7:0] > MAX_LEN)) begin
              state_d = HUNT;
              err_d   = 1'b1;
            end else begin
              state_d = DATA;
              len_d   = sh_nx[7:0];
              byte_d  = '0;
            end
          end
        end
        DATA: if (bit_valid) begin
          sh_d  = sh_nx[14:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            sh_d   = '0;
            cnt_d  = '0;
            byte_d = byte_q + 8'd1;
            if (out_valid_q && !out_ready) begin
              state_d = HUNT;
              err_d   = 1'b1;
            end else begin
              out_data_d  = sh_nx[7:0];
              out_valid_d = 1'b1;
              out_last_d  = (byte_d == len_q);
              if (byte_d == len_q) begin
`ifdef FSK_FRAME_CRC_EN
                state_d = CRC;
`else
                state_d = HUNT;
                ok_d    = 1'b1;
`endif
              end
            end
          end
        end
`ifdef FSK_FRAME_CRC_EN
        CRC: if (bit_valid) begin
          sh_d  = sh_nx[14:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            sh_d    = '0;
            cnt_d   = '0;
            state_d = HUNT;
            ok_d    = (sh_nx[7:0] == crc_val);
            err_d   = (sh_nx[7:0] != crc_val);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alt_q       <= '0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      len_q       <= '0;
      byte_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      start_q     <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alt_q       <= alt_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      len_q       <= len_d;
      byte_q      <= byte_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      start_q     <= start_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign frame_start = start_q;
  assign frame_ok    = ok_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != IDLE) && (state_q != HUNT);

endmodule

// File: tb/tb_fsk_frame_ctrl.sv
// Directed bench for fsk_frame_ctrl: framing, length limits, sync timeout, overflow, enable drop.
module tb_fsk_frame_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_start, frame_ok, frame_err, busy;

  int         checks = 0, failures = 0;
  int         n_start = 0, n_ok = 0, n_err = 0;
  logic [8:0] rxq[$];
  logic [7:0] crc_m;

  always #5 clk = ~clk;

  fsk_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_start (frame_start),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Inputs change at posedge+1, so a negedge sample sees the values the next posedge will use.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start) n_start++;
      if (frame_ok)    n_ok++;
      if (frame_err)   n_err++;
      if (frame_start || frame_ok || frame_err)
        chk("pulse_onehot", int'(frame_start) + int'(frame_ok) + int'(frame_err), 1);
      if (out_valid && out_ready) rxq.push_back({out_last, out_data});
    end
  end

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      logic fb = r[7] ^ d[i];
      r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_pre();
    for (int i = 0; i < 8; i++) send_bit((i % 2) == 0);
  endtask

  task automatic tx_hdr(input logic [7:0] len);
    send_pre();
    send_byte(8'hD3);
    send_byte(8'h91);
    send_byte(len);
    crc_m = crc_upd(8'h00, len);
  endtask

  task automatic tx_data(input logic [7:0] b);
    send_byte(b);
    crc_m = crc_upd(crc_m, b);
  endtask

  task automatic tx_crc();
`ifdef FSK_FRAME_CRC_EN
    send_byte(crc_m);
`endif
  endtask

  task automatic clr();
    n_start = 0; n_ok = 0; n_err = 0;
    rxq.delete();
  endtask

  initial begin
    cyc(3);
    chk("reset_outs", {out_data, out_valid, out_last, frame_start, frame_ok, frame_err, busy}, 0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    cyc(2);

    // Basic frame L=2, A5 3C
    clr(); out_ready = 1'b1;
    tx_hdr(8'd2);
    chk("t1_busy", busy, 1);
    tx_data(8'hA5);
    chk("t1_vld", out_valid, 1);
    chk("t1_dat0", out_data, 8'hA5);
    chk("t1_last0", out_last, 0);
    tx_data(8'h3C);
    chk("t1_dat1", out_data, 8'h3C);
    chk("t1_last1", out_last, 1);
`ifndef FSK_FRAME_CRC_EN
    chk("t1_ok_pulse", frame_ok, 1);
`endif
    tx_crc();
    cyc(3);
    chk("t1_nstart", n_start, 1);
    chk("t1_nok", n_ok, 1);
    chk("t1_nerr", n_err, 0);
    chk("t1_nbytes", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("t1_rx0", rxq[0], {1'b0, 8'hA5});
      chk("t1_rx1", rxq[1], {1'b1, 8'h3C});
    end
    chk("t1_busy_end", busy, 0);

    // Illegal lengths, then the largest legal length
    clr();
    tx_hdr(8'd0);
    chk("t2_err_l0", frame_err, 1);
    chk("t2_busy_l0", busy, 0);
    tx_hdr(8'd65);
    chk("t2_err_l65", frame_err, 1);
    tx_hdr(8'd64);
    for (int i = 1; i <= 64; i++) tx_data(8'(i));
    tx_crc();
    cyc(3);
    chk("t2_nerr", n_err, 2);
    chk("t2_nok", n_ok, 1);
    chk("t2_nbytes", rxq.size(), 64);
    if (rxq.size() == 64) begin
      chk("t2_rx62", rxq[62], {1'b0, 8'd63});
      chk("t2_rx63", rxq[63], {1'b1, 8'd64});
    end

    // Sync search timeout after 32 non-matching bits
    clr();
    send_pre();
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    chk("t3_busy31", busy, 1);
    send_bit(1'b0);
    chk("t3_busy32", busy, 0);
    cyc(2);
    chk("t3_pulses", n_start + n_ok + n_err, 0);

    // Overflow with out_ready held low
    clr(); out_ready = 1'b0;
    tx_hdr(8'd3);
    tx_data(8'h11);
    chk("t4_vld", out_valid, 1);
    tx_data(8'h22);
    chk("t4_err", frame_err, 1);
    chk("t4_held_dat", out_data, 8'h11);
    chk("t4_busy", busy, 0);
    cyc(3);
    chk("t4_held_vld", out_valid, 1);
    out_ready = 1'b1;
    cyc(3);
    chk("t4_nbytes", rxq.size(), 1);
    if (rxq.size() == 1) chk("t4_rx0", rxq[0], {1'b0, 8'h11});
    chk("t4_nerr", n_err, 1);

    // Enable dropped mid-frame with a byte pending
    clr(); out_ready = 1'b0;
    tx_hdr(8'd4);
    tx_data(8'h81);
    enable = 1'b0;
    cyc(1);
    chk("t5_busy", busy, 0);
    chk("t5_vld", out_valid, 1);
    chk("t5_dat", out_data, 8'h81);
    cyc(3);
    chk("t5_nostatus", n_ok + n_err, 0);
    out_ready = 1'b1;
    cyc(2);
    chk("t5_nbytes", rxq.size(), 1);
    if (rxq.size() == 1) chk("t5_rx0", rxq[0], {1'b0, 8'h81});
    enable = 1'b1;
    cyc(2);
    clr();
    tx_hdr(8'd1);
    tx_data(8'h7E);
    tx_crc();
    cyc(3);
    chk("t5_re_ok", n_ok, 1);
    chk("t5_re_err", n_err, 0);
    chk("t5_re_nbytes", rxq.size(), 1);
    if (rxq.size() == 1) chk("t5_re_rx0", rxq[0], {1'b1, 8'h7E});

`ifdef FSK_FRAME_CRC_EN
    // CRC-8/0x07 over bytes 01 00 is 0x15
    clr();
    tx_hdr(8'd1);
    tx_data(8'h00);
    send_byte(8'h15);
    cyc(2);
    chk("t6_crc_ok", n_ok, 1);
    tx_hdr(8'd1);
    tx_data(8'h00);
    send_byte(8'h08);
    cyc(2);
    chk("t6_crc_err", n_err, 1);
    chk("t6_crc_ok2", n_ok, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
